// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous pin inputs.
// Reset loads a parameterised idle level into both flops.
module sync2 #(
    parameter logic rst_val = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Pass the pin through two flops so the second one is settled
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= rst_val;
            q    <= rst_val;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioner: sync, counter debounce, edge pulses
// and optional hold-to-autorepeat strobe for a downstream enable.
module button_debouncer #(
    parameter int w          = 16,
    parameter bit active_low = 1'b1,
    parameter int rep_delay  = 0,
    parameter int rep_period = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic press,
    // "release" is a reserved word, hence the suffix
    output logic release_pulse,
    output logic strobe
);

    localparam int rep_max =
        (rep_delay > rep_period) ? rep_delay : rep_period;
    localparam int rw = $clog2(rep_max + 1);

    localparam logic [rw-1:0] delay_lim  = rw'(rep_delay);
    localparam logic [rw-1:0] period_lim = rw'(rep_period);
    localparam logic [rw-1:0] rep_one    = rw'(1);
    localparam logic [w-1:0]  db_one     = w'(1);
    localparam logic [w-1:0]  db_max     = '1;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REL_WAIT
    } state_t;

    state_t        state, state_n;
    logic [w-1:0]  db, db_n;
    logic [rw-1:0] rep, rep_n, rep_inc, rep_lim;
    logic          phase, phase_n;
    logic          level_n, press_n, rel_n, strobe_n;
    logic          rep_hit;
    logic          pin, s;

    sync2 #(.rst_val(active_low)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (pin)
    );

    // Normalise so that s = 1 means pressed
    assign s = pin ^ active_low;

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            db            <= '0;
            rep           <= '0;
            phase         <= 1'b0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            strobe        <= 1'b0;
        end else begin
            state         <= state_n;
            db            <= db_n;
            rep           <= rep_n;
            phase         <= phase_n;
            level         <= level_n;
            press         <= press_n;
            release_pulse <= rel_n;
            strobe        <= strobe_n;
        end
    end

    // Debounce FSM and autorepeat timing
    always_comb begin
        state_n = state;
        db_n    = db;
        rep_n   = rep;
        phase_n = phase;
        level_n = level;
        press_n = 1'b0;
        rel_n   = 1'b0;
        rep_hit = 1'b0;
        rep_inc = rep + rep_one;
        rep_lim = phase ? period_lim : delay_lim;

        unique case (state)
            IDLE: begin
                db_n = '0;
                if (s) begin
                    state_n = PRESS_WAIT;
                    db_n    = db_one;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_n = IDLE;
                    db_n    = '0;
                end else if (db == db_max) begin
                    state_n = HELD;
                    db_n    = '0;
                    level_n = 1'b1;
                    press_n = 1'b1;
                end else begin
                    db_n = db + db_one;
                end
            end
            HELD: begin
                db_n = '0;
                if (!s) begin
                    state_n = REL_WAIT;
                    db_n    = db_one;
                end
            end
            REL_WAIT: begin
                if (s) begin
                    state_n = HELD;
                    db_n    = '0;
                end else if (db == db_max) begin
                    state_n = IDLE;
                    db_n    = '0;
                    level_n = 1'b0;
                    rel_n   = 1'b1;
                end else begin
                    db_n = db + db_one;
                end
            end
            default: begin
                state_n = IDLE;
                db_n    = '0;
            end
        endcase

        // Repeat only while level stays high across this edge
        if (rep_delay != 0 && level && level_n) begin
            rep_n = rep_inc;
            if (rep_inc == rep_lim) begin
                rep_hit = 1'b1;
                rep_n   = '0;
                phase_n = 1'b1;
            end
        end

        // Press cycle starts the repeat count at 0
        if (!level_n || press_n) begin
            rep_n   = '0;
            phase_n = 1'b0;
        end

        strobe_n = press_n | rep_hit;
    end

endmodule
